iob_sipo_ctrl: RTL

- Controller that sequences a serial-in/parallel-out shift register into framed DATA_W-bit words.
- Accepts one serial bit per cycle under valid/ready and counts bits. Hands each completed word to a downstream consumer through a one-entry output buffer with valid/ready.
- Sits between a bit-serial receiver (SPI/UART-style front end) and word-wide logic. Exerts backpressure on the serial side only when both the shift register and the output buffer hold words.

---
 rtl/iob_sipo_ctrl_pkg.sv | 31 +++
 rtl/iob_reg.sv | 33 +++
 rtl/iob_sipo_reg.sv | 48 ++++
 rtl/iob_sipo_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_sipo_ctrl_pkg.sv
// ============================================================================
// Module      : iob_sipo_ctrl_pkg
// Description : Shared types and frame sizing for the SIPO word controller.
//               Optional feature macro: IOB_SIPO_CTRL_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_sipo_ctrl_pkg;

    localparam int DATA_W_DEFAULT = 8;

`ifdef IOB_SIPO_CTRL_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [0:0] {
        SHIFT = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Serial bits per frame: data bits plus the trailing parity bit, if any.
    function automatic int frame_len(input int data_w);
        return data_w + PARITY_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_reg.sv
// ============================================================================
// Module      : iob_reg
// Description : Clock-enabled register with asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_reg #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (cke_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/iob_sipo_reg.sv
// ============================================================================
// Module      : iob_sipo_reg
// Description : Serial-in/parallel-out shift register, MSB-first, with a
//               synchronous clear that wins over a shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_sipo_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              s_i,
    output logic [DATA_W-1:0] p_o
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = {sr_q[DATA_W-2:0], s_i};
        end
    end

    iob_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL ('0)
    ) u_sr_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (sr_d),
        .data_o (sr_q)
    );

    assign p_o = sr_q;

endmodule

`default_nettype wire

// File: rtl/iob_sipo_ctrl.sv
// ============================================================================
// Module      : iob_sipo_ctrl
// Description : Frames a valid/ready bit stream into DATA_W-bit words held in
//               a one-entry output buffer. Optional trailing parity bit check
//               enabled by macro IOB_SIPO_CTRL_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_sipo_ctrl
    import iob_sipo_ctrl_pkg::*;
#(
    parameter int  DATA_W     = DATA_W_DEFAULT,
    parameter int  ODD_PARITY = 0,
    localparam int CNT_W      = $clog2(DATA_W + 2)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              flush_i,
    input  logic              s_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] p_o,
    output logic              p_valid_o,
`ifdef IOB_SIPO_CTRL_PARITY_EN
    output logic              p_par_err_o,
`endif
    input  logic              p_ready_i,
    output logic [CNT_W-1:0]  level_o
);

    localparam int               FRAME_LEN = frame_len(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_LEN);

    if (DATA_W < 2 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
        $error("iob_sipo_ctrl: DATA_W must be >= 2 and ODD_PARITY 0 or 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic [0:0]        state_raw_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] p_q;
    logic [DATA_W-1:0] p_d;
    logic              p_valid_q;
    logic              p_valid_d;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] word;
    logic              accept;
    logic              slot_free;
    logic              last_bit;
    logic              sr_en;

    assign s_ready_o = (state_q == SHIFT);
    assign accept    = s_valid_i & s_ready_o;
    assign slot_free = ~p_valid_q | p_ready_i;
    assign last_bit  = accept & (count_q == LAST_CNT);

`ifdef IOB_SIPO_CTRL_PARITY_EN
    localparam logic ODD_BIT = 1'(ODD_PARITY);

    logic par_q;
    logic par_d;
    logic par_err_q;
    logic par_err_d;

    // The parity bit is compared only; the data is already complete in sr.
    assign word  = sr_q;
    assign sr_en = accept & ~flush_i & (count_q < CNT_W'(DATA_W));
`else
    assign word  = {sr_q[DATA_W-2:0], s_i};
    assign sr_en = accept & ~flush_i;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        p_d       = p_q;
        p_valid_d = p_valid_q & ~p_ready_i;
`ifdef IOB_SIPO_CTRL_PARITY_EN
        par_d     = par_q;
        par_err_d = par_err_q;
`endif
        // Flush leaves the output buffer alone so its handshake still completes.
        if (flush_i) begin
            state_d = SHIFT;
            count_d = '0;
`ifdef IOB_SIPO_CTRL_PARITY_EN
            par_d   = 1'b0;
`endif
        end else if (state_q == FULL) begin
            if (slot_free) begin
                p_d       = sr_q;
                p_valid_d = 1'b1;
                count_d   = '0;
                state_d   = SHIFT;
`ifdef IOB_SIPO_CTRL_PARITY_EN
                par_err_d = par_q ^ ODD_BIT;
                par_d     = 1'b0;
`endif
            end
        end else if (accept) begin
            if (last_bit) begin
                if (slot_free) begin
                    p_d       = word;
                    p_valid_d = 1'b1;
                    count_d   = '0;
`ifdef IOB_SIPO_CTRL_PARITY_EN
                    par_err_d = par_q ^ s_i ^ ODD_BIT;
                    par_d     = 1'b0;
`endif
                end else begin
                    state_d = FULL;
                    count_d = FULL_CNT;
`ifdef IOB_SIPO_CTRL_PARITY_EN
                    par_d   = par_q ^ s_i;
`endif
                end
            end else begin
                count_d = count_q + CNT_W'(1);
`ifdef IOB_SIPO_CTRL_PARITY_EN
                par_d   = par_q ^ s_i;
`endif
            end
        end
    end

    iob_sipo_reg #(
        .DATA_W (DATA_W)
    ) u_sipo (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .clr_i  (flush_i),
        .en_i   (sr_en),
        .s_i    (s_i),
        .p_o    (sr_q)
    );

    iob_reg #(
        .DATA_W  (1),
        .RST_VAL (1'b0)
    ) u_state_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (state_d),
        .data_o (state_raw_q)
    );

    assign state_q = state_t'(state_raw_q);

    iob_reg #(
        .DATA_W  (CNT_W),
        .RST_VAL ('0)
    ) u_count_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (count_d),
        .data_o (count_q)
    );

    iob_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL ('0)
    ) u_p_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (p_d),
        .data_o (p_q)
    );

    iob_reg #(
        .DATA_W  (1),
        .RST_VAL (1'b0)
    ) u_p_valid_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (p_valid_d),
        .data_o (p_valid_q)
    );

`ifdef IOB_SIPO_CTRL_PARITY_EN
    iob_reg #(
        .DATA_W  (1),
        .RST_VAL (1'b0)
    ) u_par_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (par_d),
        .data_o (par_q)
    );

    iob_reg #(
        .DATA_W  (1),
        .RST_VAL (1'b0)
    ) u_par_err_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .data_i (par_err_d),
        .data_o (par_err_q)
    );

    assign p_par_err_o = par_err_q;
`endif

    assign p_o       = p_q;
    assign p_valid_o = p_valid_q;
    assign level_o   = count_q;

endmodule

`default_nettype wire
